// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM states,
// MIPS opcode constants and the default reset fetch address.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Branch displacement: sign-extended 16-bit word offset, in bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC select for the fetch unit: jump, taken branch or
// sequential. Only the low 26 instruction bits take part in the select.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] instr_pc,
  input  logic [25:0] instr_lo,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;

  always_comb begin
    pc4 = instr_pc + 32'd4;
    next_pc = pc4;
    // Jump wins over a simultaneously asserted branch.
    if (jump) begin
      next_pc = {pc4[31:28], instr_lo, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc4 + branch_offset(instr_lo[15:0]);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: REQ -> WAIT -> ISSUE, one request outstanding at a time.
// Optional stall counter output enabled by FETCH_STALL_CNT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] instr_pc,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        zero
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  next_pc;

  next_pc_calc u_next_pc_calc (
    .instr_pc (instr_pc_q),
    .instr_lo (instr_q[25:0]),
    .branch   (Branch),
    .jump     (Jump),
    .zero     (zero),
    .next_pc  (next_pc)
  );

  // Responses outside WAIT are stale and deliberately dropped.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      REQ: begin
        if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = REQ;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // The reset input is active high despite its name; requests are masked
  // while it is asserted so the first request appears right after release.
  assign imem_req_valid = (state_q == REQ) && !rst_n;
  assign imem_addr      = pc_q;
  assign instr_valid    = (state_q == ISSUE);
  assign instr          = instr_q;
  assign opcode         = instr_q[31:26];
  assign instr_pc       = instr_pc_q;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_inc;

  always_comb begin
    stall_inc = (state_q == WAIT) ||
                ((state_q == REQ) && !imem_req_ready) ||
                ((state_q == ISSUE) && !instr_ready);
    stall_d = stall_q;
    if (stall_inc && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, jump/branch select,
// stale responses, stalls and reset abort.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
  logic        Branch;
  logic        Jump;
  logic        zero;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .opcode         (opcode),
    .instr_pc       (instr_pc),
    .Branch         (Branch),
    .Jump           (Jump),
    .zero           (zero)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge in REQ; leaves at the negedge after the issue handshake.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] word,
                           input logic br, input logic jp, input logic zr,
                           input logic [31:0] exp_next);
    imem_rsp_valid = 1'b0;
    check("req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("req_addr", imem_addr, addr);
    check("req_instr_valid", {31'd0, instr_valid}, 32'd0);
    imem_req_ready = 1'b1;
    Branch = 1'b1; Jump = 1'b1; zero = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("wait_instr_valid", {31'd0, instr_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rdata     = word;
    @(negedge clk);
    imem_rdata     = ~word;
    check("issue_valid", {31'd0, instr_valid}, 32'd1);
    check("issue_instr", instr, word);
    check("issue_opcode", {26'd0, opcode}, {26'd0, word[31:26]});
    check("issue_pc", instr_pc, addr);
    instr_ready = 1'b1;
    Branch = br; Jump = jp; zero = zr;
    @(negedge clk);
    instr_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    Branch = 1'b0; Jump = 1'b0; zero = 1'b0;
    check("next_addr", imem_addr, exp_next);
    check("stale_rsp_instr", instr, word);
    $display("[TB] fetch pc=%08h word=%08h br=%0b j=%0b z=%0b -> next=%08h",
             addr, word, br, jp, zr, imem_addr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = 32'd0;
    instr_ready = 1'b0; Branch = 1'b0; Jump = 1'b0; zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_opcode", {26'd0, opcode}, 32'd0);
    check("rst_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_STALL_CNT_EN
    check("rst_stall", stall_cycles, 32'd0);
`endif
    rst_n = 1'b0;
    #1;
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);

    fetch_one(32'h0000_0000, 32'h2001_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
    fetch_one(32'h0000_0004, 32'h2002_0002, 1'b0, 1'b0, 1'b0, 32'h0000_0008);
    fetch_one(32'h0000_0008, 32'h2003_0003, 1'b0, 1'b0, 1'b1, 32'h0000_000C);
    check("addi_opcode", {26'd0, opcode}, 32'h08);
    fetch_one(32'h0000_000C, 32'h0800_0040, 1'b0, 1'b1, 1'b0, 32'h0000_0100);
    fetch_one(32'h0000_0100, 32'h0800_0040, 1'b0, 1'b1, 1'b0, 32'h0000_0100);
    fetch_one(32'h0000_0100, 32'h0800_0008, 1'b0, 1'b1, 1'b0, 32'h0000_0020);
    fetch_one(32'h0000_0020, 32'h1000_FFFC, 1'b1, 1'b0, 1'b1, 32'h0000_0014);
    fetch_one(32'h0000_0014, 32'h0800_0008, 1'b0, 1'b1, 1'b0, 32'h0000_0020);
    fetch_one(32'h0000_0020, 32'h1000_FFFC, 1'b1, 1'b0, 1'b0, 32'h0000_0024);
    fetch_one(32'h0000_0024, 32'h1000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0000);
    fetch_one(32'h0000_0000, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 32'h0000_0004);
    fetch_one(32'h0000_0004, 32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 32'h0000_0000);
    fetch_one(32'h0000_0000, 32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 32'h2001_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000);

    // Reset while WAIT, stale response in the first REQ cycle after release.
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("rstwait_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("rstwait_addr", imem_addr, 32'h0);
    check("rstwait_instr_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    check("rstwait_still_req", {31'd0, imem_req_valid}, 32'd1);
    check("rstwait_no_issue", {31'd0, instr_valid}, 32'd0);
    check("rstwait_instr", instr, 32'h0);
    $display("[TB] reset-in-wait: req_valid=%0b addr=%08h instr_valid=%0b",
             imem_req_valid, imem_addr, instr_valid);
    fetch_one(32'h0000_0000, 32'h2004_0004, 1'b0, 1'b0, 1'b0, 32'h0000_0004);

    // Stalls: 4 REQ cycles without ready, 3 WAIT cycles, 2 ISSUE cycles without ready.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("stall_req_addr", imem_addr, 32'h0);
      @(negedge clk);
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("stall_wait_addr", imem_addr, 32'h0);
      check("stall_wait_valid", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
    end
    imem_rsp_valid = 1'b1;
    imem_rdata = 32'h8C22_0010;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("stall_issue_instr", instr, 32'h8C22_0010);
      check("stall_issue_valid", {31'd0, instr_valid}, 32'd1);
      @(negedge clk);
    end
    check("stall_issue_hold", instr, 32'h8C22_0010);
`ifdef FETCH_STALL_CNT_EN
    check("stall_cycles", stall_cycles, 32'd9);
`endif
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("stall_next_addr", imem_addr, 32'h0000_0004);
    $display("[TB] stall sequence done next=%08h", imem_addr);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer that sits in front of the control unit and datapath: it owns the PC, fetches 32-bit MIPS instructions over a valid/ready memory interface, and issues them downstream with the opcode split out for decode. Control signals `Branch` and `Jump` and the ALU `zero` flag are consumed on the return path to select the next PC. This block produces the `Opcode` that the decoder consumes and consumes the decoder's `Branch`/`Jump` results.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `rst_n`  in  1  synchronous, active-high reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_addr`  out  32  fetch byte address, held stable while `imem_req_valid`
- `imem_rsp_valid`  in  1  fetch data valid, one-cycle pulse
- `imem_rdata`  in  32  fetched instruction word
- `instr_valid`  out  1  issued instruction valid
- `instr_ready`  in  1  downstream accepts instruction
- `instr`  out  32  instruction register
- `opcode`  out  6  `instr[31:26]`
- `instr_pc`  out  32  address of `instr`
- `Branch`  in  1  from control unit, sampled at issue handshake
- `Jump`  in  1  from control unit, sampled at issue handshake
- `zero`  in  1  ALU equality result, sampled at issue handshake
- `stall_cycles`  out  32  present only with `FETCH_STALL_CNT_EN`

## Operation
- FSM states: REQ, WAIT, ISSUE.
- REQ: `imem_req_valid`=1, `imem_addr`=PC. On `imem_req_valid && imem_req_ready` -> WAIT.
- WAIT: on `imem_rsp_valid`, capture `imem_rdata` into `instr`, `instr_pc`<=PC -> ISSUE.
- ISSUE: `instr_valid`=1, `instr`/`opcode`/`instr_pc` held stable. On `instr_valid && instr_ready`, PC<=next_pc -> REQ.
- next_pc, with pc4 = `instr_pc`+4 (mod 2^32, wraps at 32'hFFFF_FFFC -> 0):
  - `Jump`=1: {pc4[31:28], instr[25:0], 2'b00}. Jump has priority over Branch.
  - `Branch`=1 and `zero`=1: pc4 + (sign_extend(instr[15:0]) << 2), 32-bit wrap.
  - otherwise: pc4.
- `Branch`, `Jump`, and `zero` are ignored outside the issue handshake cycle.
- At most one request outstanding. `imem_rsp_valid` in REQ or ISSUE is ignored (stale response); instruction and PC are unchanged.
- `imem_rsp_valid` in the same cycle as request acceptance is not captured; the response is taken in WAIT only.
- Reset in any state, including mid-request or mid-issue, aborts immediately. Any pending response is dropped by the rule above.

## Timing
- Reset values: state=REQ, PC=`RESET_PC`, `imem_req_valid`=0 while `rst_n`=1, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=0, `opcode`=0, `instr_pc`=0, `stall_cycles`=0.
- First request: `imem_req_valid`=1 in the first cycle with `rst_n`=0.
- With zero-wait memory (ready high, response the cycle after acceptance) and `instr_ready` high, there is 1 cycle each in REQ, WAIT, and ISSUE. Throughput is 1 instruction per 3 cycles.
- `instr_valid` rises the cycle after the captured `imem_rsp_valid`.
- `imem_req_valid` rises the cycle after the issue handshake and carries next_pc.
- All outputs are registered or decoded from state only. There is no combinational path from `instr_ready`, `Branch`, `Jump`, or `zero` to any output.

## Configuration
- `FETCH_STALL_CNT_EN` defined:
  - `stall_cycles` port exists.
  - It increments by 1 each cycle in WAIT, each cycle in REQ with `imem_req_ready`=0, and each cycle in ISSUE with `instr_ready`=0.
  - It saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (REQ, WAIT, ISSUE)
  - opcode constants OPC_RTYPE=6'b000000, OPC_BEQ=6'b000100, OPC_J=6'b000010, OPC_LW=6'b100011, OPC_SW=6'b101011, OPC_ADDI=6'b001000
  - default `RESET_PC`
- One sub-module, `next_pc_calc`: combinational next-PC select from `instr_pc`, `instr`, `Branch`, `Jump`, and `zero`.

## Test plan
- Reset, zero-wait memory, 3 sequential addi words, `instr_ready`=1 -> addresses 0x0, 0x4, 0x8; `instr_valid` pulses every 3rd cycle; `opcode`=6'b001000.
- At `instr_pc`=0x100, issue j with instr[25:0]=0x40 and `Jump`=1 -> next `imem_addr`=0x100.
- At 0x20, issue beq with imm=16'hFFFC, `Branch`=1, `zero`=1 -> next addr 0x14. Same instruction with `zero`=0 -> next addr 0x24.
- Hold `imem_req_ready`=0 for 4 cycles, then delay the response 3 cycles, then hold `instr_ready`=0 for 2 cycles -> `imem_addr` and `instr` stay stable throughout; `stall_cycles`=9 with `FETCH_STALL_CNT_EN`.
- Assert reset in WAIT, with the response arriving in the first post-reset REQ cycle -> response ignored; request reissued at `RESET_PC`; `instr_valid` stays 0 until the new response.
- `instr_pc`=0xFFFF_FFFC, sequential -> next `imem_addr`=0x0000_0000.
